// File: rtl/chess_btn_pkg.sv
// Shared button indices, command codes and arbiter state type for the chess button front end.
package chess_btn_pkg;

    localparam int NUM_BTN = 5;
    localparam int CODE_W  = 3;

    // Bit positions within the {C,U,D,L,R} button vector
    localparam int BTN_R = 0;
    localparam int BTN_L = 1;
    localparam int BTN_D = 2;
    localparam int BTN_U = 3;
    localparam int BTN_C = 4;

    typedef enum logic [CODE_W-1:0] {
        CMD_NONE = 3'd0,
        CMD_C    = 3'd1,
        CMD_U    = 3'd2,
        CMD_D    = 3'd3,
        CMD_L    = 3'd4,
        CMD_R    = 3'd5
    } cmd_code_t;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_SERVE,
        ARB_STALL
    } arb_state_t;

    function automatic logic [CODE_W-1:0] btn_code(input int idx);
        case (idx)
            BTN_C:   btn_code = CMD_C;
            BTN_U:   btn_code = CMD_U;
            BTN_D:   btn_code = CMD_D;
            BTN_L:   btn_code = CMD_L;
            BTN_R:   btn_code = CMD_R;
            default: btn_code = CMD_NONE;
        endcase
    endfunction

endpackage

// File: rtl/btn_cmd_scheduler_if.sv
// Valid/ready command handshake between the button scheduler and the game FSM.
interface btn_cmd_scheduler_if #(
    parameter int CODE_W = 3
);
    logic              Cmd_valid;
    logic [CODE_W-1:0] Cmd_code;
    logic              Cmd_ready;

    modport master (output Cmd_valid, output Cmd_code, input Cmd_ready);
    modport slave  (input Cmd_valid, input Cmd_code, output Cmd_ready);
endinterface

// File: rtl/btn_cmd_scheduler_cmd_fifo.sv
// Show-ahead synchronous command FIFO; rdata always presents the head entry.
module cmd_fifo #(
    parameter int DEPTH  = 4,
    parameter int CODE_W = 3,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              flush,
    input  logic              push,
    input  logic              pop,
    input  logic [CODE_W-1:0] wdata,
    output logic [CODE_W-1:0] rdata,
    output logic              full,
    output logic              empty,
    output logic [CNT_W-1:0]  count
);

    logic [CODE_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              wr_en;
    logic              rd_en;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
    assign rd_en = pop & ~empty;
    // A write into a full FIFO is legal only when the head leaves in the same cycle
    assign wr_en = push & (~full | rd_en);
    assign rdata = mem[rd_ptr];

    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/btn_cmd_scheduler.sv
// Turns debounced button levels into a prioritised, buffered command stream for the game FSM.
module btn_cmd_scheduler #(
    parameter int DEPTH  = 4,
    parameter int CODE_W = 3
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic [4:0]                 Btn_pulse,
    input  logic                       Cmd_en,
    input  logic                       Clear,
    btn_cmd_scheduler_if.master        cmd,
    output logic                       Overflow,
    output logic                       Busy
);
    import chess_btn_pkg::*;

    localparam int CNT_W = $clog2(DEPTH + 1);

    arb_state_t         state;
    logic [NUM_BTN-1:0] prev;
    logic [NUM_BTN-1:0] pending;
    logic [NUM_BTN-1:0] rise;
    logic [NUM_BTN-1:0] grant;
    logic [NUM_BTN-1:0] grant_eff;
    logic [NUM_BTN-1:0] pending_nxt;
    logic               hit;
    logic               lost;
    logic               push;
    logic               pop;
    logic               full;
    logic               empty;
    logic [CNT_W-1:0]   count;
    logic [CODE_W-1:0]  push_code;
    logic [CODE_W-1:0]  head_code;

    assign rise = Cmd_en ? (Btn_pulse & ~prev) : '0;

    // Fixed priority C > U > D > L > R, i.e. highest bit index first
    always_comb begin
        grant     = '0;
        push_code = '0;
        hit       = 1'b0;
        for (int i = NUM_BTN - 1; i >= 0; i--) begin
            if (pending[i] && !hit) begin
                hit       = 1'b1;
                grant[i]  = 1'b1;
                push_code = CODE_W'(btn_code(i));
            end
        end
    end

    assign pop       = ~empty & cmd.Cmd_ready;
    assign push      = (state != ARB_IDLE) & (|pending) & (~full | pop);
    assign grant_eff = push ? grant : '0;
    // A fresh press on a bit being served this cycle re-arms it rather than counting as lost
    assign pending_nxt = (pending & ~grant_eff) | rise;
    assign lost        = |(rise & pending & ~grant_eff);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state    <= ARB_IDLE;
            prev     <= '1;
            pending  <= '0;
            Overflow <= 1'b0;
        end else if (Clear) begin
            state    <= ARB_IDLE;
            prev     <= Btn_pulse;
            pending  <= '0;
            Overflow <= 1'b0;
        end else begin
            prev    <= Btn_pulse;
            pending <= pending_nxt;
            if (lost) Overflow <= 1'b1;
            if (pending_nxt == '0)  state <= ARB_IDLE;
            else if (full && !pop)  state <= ARB_STALL;
            else                    state <= ARB_SERVE;
        end
    end

    cmd_fifo #(
        .DEPTH  (DEPTH),
        .CODE_W (CODE_W)
    ) u_fifo (
        .CLK   (CLK),
        .RESET (RESET),
        .flush (Clear),
        .push  (push),
        .pop   (pop),
        .wdata (push_code),
        .rdata (head_code),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    assign cmd.Cmd_valid = ~empty;
    assign cmd.Cmd_code  = empty ? '0 : head_code;
    assign Busy          = (|pending) | (count != '0);

endmodule

// File: tb/tb_btn_cmd_scheduler.sv
// Directed bench for btn_cmd_scheduler: latency, priority ordering, stall, overflow, clear and reset.
module tb_btn_cmd_scheduler;

    logic       CLK = 1'b0;
    logic       RESET;
    logic [4:0] Btn_pulse;
    logic       Cmd_en;
    logic       Clear;
    logic       Overflow;
    logic       Busy;
    int         checks = 0;
    int         errors = 0;

    btn_cmd_scheduler_if #(.CODE_W(3)) cmd_if ();

    btn_cmd_scheduler #(.DEPTH(4), .CODE_W(3)) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .Btn_pulse (Btn_pulse),
        .Cmd_en    (Cmd_en),
        .Clear     (Clear),
        .cmd       (cmd_if.master),
        .Overflow  (Overflow),
        .Busy      (Busy)
    );

    always #5 CLK = ~CLK;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        tick();
        tick();
        RESET = 1'b0;
        tick();
        checks++;
        if ({cmd_if.Cmd_valid, cmd_if.Cmd_code, Overflow, Busy} !== 6'b0) begin
            errors++;
            $display("FAIL reset_outputs: got valid=%0b code=%0d ovf=%0b busy=%0b required all 0",
                     cmd_if.Cmd_valid, cmd_if.Cmd_code, Overflow, Busy);
        end
    endtask

    task automatic test_single_hold();
        int first = -1;
        int nvalid = 0;
        cmd_if.Cmd_ready = 1'b1;
        Btn_pulse = 5'b01000;
        for (int i = 1; i <= 8000; i++) begin
            tick();
            if (cmd_if.Cmd_valid) begin
                nvalid++;
                if (first < 0) first = i;
                checks++;
                if (cmd_if.Cmd_code !== 3'd2) begin
                    errors++;
                    $display("FAIL hold_code: got %0d required 2", cmd_if.Cmd_code);
                end
            end
        end
        checks++;
        if (first != 2) begin
            errors++;
            $display("FAIL hold_latency: got %0d required 2", first);
        end
        checks++;
        if (nvalid != 1) begin
            errors++;
            $display("FAIL hold_count: got %0d required 1", nvalid);
        end
        Btn_pulse = 5'b0;
        tick();
        tick();
        checks++;
        if (Busy !== 1'b0) begin
            errors++;
            $display("FAIL hold_busy: got %0b required 0", Busy);
        end
    endtask

    task automatic test_simultaneous();
        logic [2:0] got [1:6];
        logic       bsy [1:6];
        logic [2:0] exp [1:6];
        exp = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd0, 3'd0};
        cmd_if.Cmd_ready = 1'b1;
        Btn_pulse = 5'b10011;
        for (int i = 1; i <= 6; i++) begin
            tick();
            got[i] = cmd_if.Cmd_valid ? cmd_if.Cmd_code : 3'd0;
            bsy[i] = Busy;
        end
        for (int i = 1; i <= 6; i++) begin
            checks++;
            if (got[i] !== exp[i]) begin
                errors++;
                $display("FAIL simul_code[%0d]: got %0d required %0d", i, got[i], exp[i]);
            end
        end
        checks++;
        if (bsy[5] !== 1'b0) begin
            errors++;
            $display("FAIL simul_busy: got %0b required 0", bsy[5]);
        end
        Btn_pulse = 5'b0;
        tick();
    endtask

    task automatic test_stall_order();
        int         order [6];
        logic [2:0] exp [6];
        logic [2:0] got [8];
        int         n = 0;
        order = '{3, 2, 1, 0, 4, 3};
        exp   = '{3'd2, 3'd3, 3'd4, 3'd5, 3'd1, 3'd2};
        cmd_if.Cmd_ready = 1'b0;
        for (int p = 0; p < 6; p++) begin
            Btn_pulse = 5'b1 << order[p];
            tick();
            tick();
            Btn_pulse = 5'b0;
            tick();
        end
        tick();
        checks++;
        if ({cmd_if.Cmd_valid, cmd_if.Cmd_code, Busy, Overflow} !== {1'b1, 3'd2, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL stall_state: got valid=%0b code=%0d busy=%0b ovf=%0b required 1 2 1 0",
                     cmd_if.Cmd_valid, cmd_if.Cmd_code, Busy, Overflow);
        end
        cmd_if.Cmd_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (cmd_if.Cmd_valid && n < 8) begin
                got[n] = cmd_if.Cmd_code;
                n++;
            end
            tick();
        end
        checks++;
        if (n != 6) begin
            errors++;
            $display("FAIL stall_count: got %0d required 6", n);
        end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (i < n && got[i] !== exp[i]) begin
                errors++;
                $display("FAIL stall_order[%0d]: got %0d required %0d", i, got[i], exp[i]);
            end
        end
        checks++;
        if ({Overflow, Busy} !== 2'b00) begin
            errors++;
            $display("FAIL stall_end: got ovf=%0b busy=%0b required 0 0", Overflow, Busy);
        end
    endtask

    task automatic test_overflow_clear();
        int nvalid = 0;
        cmd_if.Cmd_ready = 1'b0;
        Btn_pulse = 5'b11011;
        tick();
        Btn_pulse = 5'b0;
        repeat (5) tick();
        Btn_pulse = 5'b00100;
        tick();
        Btn_pulse = 5'b0;
        tick();
        checks++;
        if (Overflow !== 1'b0) begin
            errors++;
            $display("FAIL ovf_before: got %0b required 0", Overflow);
        end
        Btn_pulse = 5'b00100;
        tick();
        checks++;
        if ({Overflow, cmd_if.Cmd_valid, cmd_if.Cmd_code} !== {1'b1, 1'b1, 3'd1}) begin
            errors++;
            $display("FAIL ovf_set: got ovf=%0b valid=%0b code=%0d required 1 1 1",
                     Overflow, cmd_if.Cmd_valid, cmd_if.Cmd_code);
        end
        Btn_pulse = 5'b0;
        tick();
        Clear = 1'b1;
        tick();
        Clear = 1'b0;
        checks++;
        if ({cmd_if.Cmd_valid, cmd_if.Cmd_code, Busy, Overflow} !== 6'b0) begin
            errors++;
            $display("FAIL clear_outputs: got valid=%0b code=%0d busy=%0b ovf=%0b required all 0",
                     cmd_if.Cmd_valid, cmd_if.Cmd_code, Busy, Overflow);
        end
        cmd_if.Cmd_ready = 1'b1;
        repeat (6) begin
            tick();
            if (cmd_if.Cmd_valid) nvalid++;
        end
        checks++;
        if (nvalid != 0) begin
            errors++;
            $display("FAIL clear_stale: got %0d commands required 0", nvalid);
        end
    endtask

    task automatic test_held_reset_and_enable();
        int nvalid = 0;
        int seen = 0;
        cmd_if.Cmd_ready = 1'b1;
        Btn_pulse = 5'b11111;
        RESET = 1'b1;
        tick();
        tick();
        RESET = 1'b0;
        repeat (10) begin
            tick();
            if (cmd_if.Cmd_valid) nvalid++;
        end
        checks++;
        if (nvalid != 0) begin
            errors++;
            $display("FAIL held_reset: got %0d commands required 0", nvalid);
        end
        Btn_pulse = 5'b0;
        tick();
        tick();
        Cmd_en = 1'b0;
        Btn_pulse = 5'b01000;
        tick();
        Btn_pulse = 5'b0;
        nvalid = 0;
        repeat (6) begin
            tick();
            if (cmd_if.Cmd_valid || Busy) nvalid++;
        end
        checks++;
        if (nvalid != 0) begin
            errors++;
            $display("FAIL en_off: got %0d active cycles required 0", nvalid);
        end
        Cmd_en = 1'b1;
        Btn_pulse = 5'b01000;
        tick();
        Btn_pulse = 5'b0;
        repeat (6) begin
            tick();
            if (cmd_if.Cmd_valid && cmd_if.Cmd_code == 3'd2) seen++;
        end
        checks++;
        if (seen != 1) begin
            errors++;
            $display("FAIL en_on: got %0d U commands required 1", seen);
        end
    endtask

    task automatic test_reset_midflight();
        int nvalid = 0;
        cmd_if.Cmd_ready = 1'b0;
        Btn_pulse = 5'b11111;
        repeat (4) tick();
        checks++;
        if ({cmd_if.Cmd_valid, cmd_if.Cmd_code, Busy} !== {1'b1, 3'd1, 1'b1}) begin
            errors++;
            $display("FAIL mid_before: got valid=%0b code=%0d busy=%0b required 1 1 1",
                     cmd_if.Cmd_valid, cmd_if.Cmd_code, Busy);
        end
        RESET = 1'b1;
        tick();
        checks++;
        if ({cmd_if.Cmd_valid, cmd_if.Cmd_code, Overflow, Busy} !== 6'b0) begin
            errors++;
            $display("FAIL mid_reset: got valid=%0b code=%0d ovf=%0b busy=%0b required all 0",
                     cmd_if.Cmd_valid, cmd_if.Cmd_code, Overflow, Busy);
        end
        RESET = 1'b0;
        cmd_if.Cmd_ready = 1'b1;
        repeat (10) begin
            tick();
            if (cmd_if.Cmd_valid || Busy) nvalid++;
        end
        checks++;
        if (nvalid != 0) begin
            errors++;
            $display("FAIL mid_stale: got %0d active cycles required 0", nvalid);
        end
        Btn_pulse = 5'b0;
        tick();
    endtask

    initial begin
        RESET            = 1'b1;
        Btn_pulse        = 5'b0;
        Cmd_en           = 1'b1;
        Clear            = 1'b0;
        cmd_if.Cmd_ready = 1'b0;
        test_reset();
        test_single_hold();
        test_simultaneous();
        test_stall_order();
        test_overflow_clear();
        test_held_reset_and_enable();
        test_reset_midflight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
